// File: rtl/id_stage_pkg.sv
// Shared RV32I decode constants: opcodes, funct codes, internal op enumeration,
// stage state encodings and the decoder result record.
package id_stage_pkg;

  localparam int XLEN = 32;
  localparam int OP_W = 6;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  typedef enum logic [OP_W-1:0] {
    OP_NOP, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND
  } op_e;

  typedef struct packed {
    op_e             op;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic            uses_rs1;
    logic            uses_rs2;
    logic            rd_we;
    logic            illegal;
  } dec_t;

endpackage

// File: rtl/id_stage_if.sv
// Fetch, register-file and execute handshakes of the decode stage.
// slave = the stage itself, master = the surrounding pipeline.
interface id_stage_if;
  import id_stage_pkg::*;

  logic            if_valid;
  logic [XLEN-1:0] if_inst;
  logic [XLEN-1:0] if_pc;
  logic            id_ready;

  logic [4:0]      rs1;
  logic            rs1_read_rdy;
  logic [XLEN-1:0] rs1_val;
  logic            rs1_read_fin;
  logic [4:0]      rs2;
  logic            rs2_read_rdy;
  logic [XLEN-1:0] rs2_val;
  logic            rs2_read_fin;

  logic            ex_valid;
  logic            ex_ready;
  logic [XLEN-1:0] ex_pc;
  logic [OP_W-1:0] ex_op;
  logic [XLEN-1:0] ex_rs1_val;
  logic [XLEN-1:0] ex_rs2_val;
  logic [XLEN-1:0] ex_imm;
  logic [4:0]      ex_rd;
  logic            ex_rd_we;
  logic            ex_illegal;

  modport slave (
    input  if_valid, if_inst, if_pc, rs1_val, rs1_read_fin, rs2_val, rs2_read_fin, ex_ready,
    output id_ready, rs1, rs1_read_rdy, rs2, rs2_read_rdy,
    output ex_valid, ex_pc, ex_op, ex_rs1_val, ex_rs2_val, ex_imm, ex_rd, ex_rd_we, ex_illegal
  );

  modport master (
    output if_valid, if_inst, if_pc, rs1_val, rs1_read_fin, rs2_val, rs2_read_fin, ex_ready,
    input  id_ready, rs1, rs1_read_rdy, rs2, rs2_read_rdy,
    input  ex_valid, ex_pc, ex_op, ex_rs1_val, ex_rs2_val, ex_imm, ex_rd, ex_rd_we, ex_illegal
  );
endinterface

// File: rtl/id_stage_decoder.sv
// RV32I instruction decoder: op, immediate, register usage, rd write, illegal flag.
// Purely combinational, zero latency, no backpressure.
module id_decoder import id_stage_pkg::*; (
  input  logic [XLEN-1:0] inst_i,
  output dec_t            dec_o
);

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  dec_t            d;

  assign opcode = inst_i[6:0];
  assign f3     = inst_i[14:12];
  assign f7     = inst_i[31:25];
  assign imm_i  = {{20{inst_i[31]}}, inst_i[31:20]};
  assign imm_s  = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_b  = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_u  = {inst_i[31:12], 12'b0};
  assign imm_j  = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

  always_comb begin
    d.op       = OP_NOP;
    d.imm      = '0;
    d.rd       = inst_i[11:7];
    d.uses_rs1 = 1'b0;
    d.uses_rs2 = 1'b0;
    d.rd_we    = 1'b0;
    d.illegal  = 1'b0;
    case (opcode)
      OPC_LUI:   begin d.op = OP_LUI;   d.imm = imm_u; d.rd_we = 1'b1; end
      OPC_AUIPC: begin d.op = OP_AUIPC; d.imm = imm_u; d.rd_we = 1'b1; end
      OPC_JAL:   begin d.op = OP_JAL;   d.imm = imm_j; d.rd_we = 1'b1; end
      OPC_JALR: begin
        d.op = OP_JALR; d.imm = imm_i; d.uses_rs1 = 1'b1; d.rd_we = 1'b1;
        d.illegal = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        d.imm = imm_b; d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1;
        case (f3)
          3'b000:  d.op = OP_BEQ;
          3'b001:  d.op = OP_BNE;
          3'b100:  d.op = OP_BLT;
          3'b101:  d.op = OP_BGE;
          3'b110:  d.op = OP_BLTU;
          3'b111:  d.op = OP_BGEU;
          default: d.illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        d.imm = imm_i; d.uses_rs1 = 1'b1; d.rd_we = 1'b1;
        case (f3)
          3'b000:  d.op = OP_LB;
          3'b001:  d.op = OP_LH;
          3'b010:  d.op = OP_LW;
          3'b100:  d.op = OP_LBU;
          3'b101:  d.op = OP_LHU;
          default: d.illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        d.imm = imm_s; d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1;
        case (f3)
          3'b000:  d.op = OP_SB;
          3'b001:  d.op = OP_SH;
          3'b010:  d.op = OP_SW;
          default: d.illegal = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        d.imm = imm_i; d.uses_rs1 = 1'b1; d.rd_we = 1'b1;
        case (f3)
          F3_ADD_SUB: d.op = OP_ADDI;
          F3_SLT:     d.op = OP_SLTI;
          F3_SLTU:    d.op = OP_SLTIU;
          F3_XOR:     d.op = OP_XORI;
          F3_OR:      d.op = OP_ORI;
          F3_AND:     d.op = OP_ANDI;
          F3_SLL: begin d.op = OP_SLLI; d.illegal = (f7 != F7_BASE); end
          default: begin
            d.op      = (f7 == F7_ALT) ? OP_SRAI : OP_SRLI;
            d.illegal = (f7 != F7_BASE) && (f7 != F7_ALT);
          end
        endcase
      end
      OPC_OP: begin
        d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1; d.rd_we = 1'b1;
        // funct7 ALT is only meaningful for SUB and SRA
        d.illegal = !((f7 == F7_BASE) ||
                      ((f7 == F7_ALT) && ((f3 == F3_ADD_SUB) || (f3 == F3_SR))));
        case (f3)
          F3_ADD_SUB: d.op = (f7 == F7_ALT) ? OP_SUB : OP_ADD;
          F3_SLL:     d.op = OP_SLL;
          F3_SLT:     d.op = OP_SLT;
          F3_SLTU:    d.op = OP_SLTU;
          F3_XOR:     d.op = OP_XOR;
          F3_SR:      d.op = (f7 == F7_ALT) ? OP_SRA : OP_SRL;
          F3_OR:      d.op = OP_OR;
          default:    d.op = OP_AND;
        endcase
      end
      default: d.illegal = 1'b1;
    endcase

    if (!d.rd_we) d.rd = 5'd0;
    if (d.rd == 5'd0) d.rd_we = 1'b0;
    if (d.illegal) begin
      d.op = OP_NOP; d.imm = '0; d.rd = 5'd0;
      d.uses_rs1 = 1'b0; d.uses_rs2 = 1'b0; d.rd_we = 1'b0;
    end
    dec_o = d;
  end

endmodule

// File: rtl/id_stage.sv
// RV32I decode/operand-fetch stage: accept, read rs1/rs2 via regfile handshake, hold for execute.
// Accept->ex_valid 1 cycle (no reads) or 2 (fins next cycle); no skid, id_ready low until consumed.
module id_stage (
  input logic      clk_in,
  input logic      rst_in,
  input logic      rdy_in,
  input logic      stall,
  id_stage_if.slave io
);
  import id_stage_pkg::*;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, imm_q, imm_d;
  logic [XLEN-1:0] rs1_val_q, rs1_val_d, rs2_val_q, rs2_val_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [4:0]      rd_q, rd_d, rs1_idx_q, rs1_idx_d, rs2_idx_q, rs2_idx_d;
  logic            rd_we_q, rd_we_d, illegal_q, illegal_d;
  logic            req1_q, req1_d, req2_q, req2_d;
  logic            en, fin1, fin2;
  dec_t            dec;

  id_decoder u_decoder (.inst_i(io.if_inst), .dec_o(dec));

  assign en   = rdy_in && !stall;
  // a finish without an outstanding request is ignored
  assign fin1 = io.rs1_read_fin && req1_q;
  assign fin2 = io.rs2_read_fin && req2_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    imm_d     = imm_q;
    op_d      = op_q;
    rd_d      = rd_q;
    rd_we_d   = rd_we_q;
    illegal_d = illegal_q;
    rs1_idx_d = rs1_idx_q;
    rs2_idx_d = rs2_idx_q;
    rs1_val_d = rs1_val_q;
    rs2_val_d = rs2_val_q;
    req1_d    = req1_q;
    req2_d    = req2_q;
    if (en) begin
      case (state_q)
        ST_IDLE: begin
          if (io.if_valid) begin
            pc_d      = io.if_pc;
            imm_d     = dec.imm;
            op_d      = dec.op;
            rd_d      = dec.rd;
            rd_we_d   = dec.rd_we;
            illegal_d = dec.illegal;
            rs1_idx_d = io.if_inst[19:15];
            rs2_idx_d = io.if_inst[24:20];
            rs1_val_d = '0;
            rs2_val_d = '0;
            req1_d    = dec.uses_rs1;
            req2_d    = dec.uses_rs2;
            state_d   = (dec.uses_rs1 || dec.uses_rs2) ? ST_READ : ST_HOLD;
          end
        end
        ST_READ: begin
          if (fin1) begin rs1_val_d = io.rs1_val; req1_d = 1'b0; end
          if (fin2) begin rs2_val_d = io.rs2_val; req2_d = 1'b0; end
          if (!req1_d && !req2_d) state_d = ST_HOLD;
        end
        ST_HOLD: if (io.ex_ready) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      imm_q     <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      rd_we_q   <= 1'b0;
      illegal_q <= 1'b0;
      rs1_idx_q <= '0;
      rs2_idx_q <= '0;
      rs1_val_q <= '0;
      rs2_val_q <= '0;
      req1_q    <= 1'b0;
      req2_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      imm_q     <= imm_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      rd_we_q   <= rd_we_d;
      illegal_q <= illegal_d;
      rs1_idx_q <= rs1_idx_d;
      rs2_idx_q <= rs2_idx_d;
      rs1_val_q <= rs1_val_d;
      rs2_val_q <= rs2_val_d;
      req1_q    <= req1_d;
      req2_q    <= req2_d;
    end
  end

  assign io.id_ready     = (state_q == ST_IDLE);
  assign io.ex_valid     = (state_q == ST_HOLD);
  assign io.rs1          = rs1_idx_q;
  assign io.rs2          = rs2_idx_q;
  assign io.rs1_read_rdy = req1_q;
  assign io.rs2_read_rdy = req2_q;
  assign io.ex_pc        = pc_q;
  assign io.ex_op        = op_q;
  assign io.ex_rs1_val   = rs1_val_q;
  assign io.ex_rs2_val   = rs2_val_q;
  assign io.ex_imm       = imm_q;
  assign io.ex_rd        = rd_q;
  assign io.ex_rd_we     = rd_we_q;
  assign io.ex_illegal   = illegal_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: stimulus pushes expected ex-side records, a negedge
// monitor pops and compares them on every execute handshake.
module tb_id_stage;
  import id_stage_pkg::*;

  typedef struct {
    logic [31:0] pc;
    logic [5:0]  op;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  logic clk_in = 1'b0;
  logic rst_in, rdy_in, stall;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t mon_e;

  id_stage_if bus();

  id_stage dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .rdy_in(rdy_in),
    .stall (stall),
    .io    (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic issue(input logic [31:0] inst, input logic [31:0] pc, input logic [5:0] op,
                       input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] imm,
                       input logic [4:0] rd, input logic we, input logic ill, input bit push);
    exp_t e;
    e.pc = pc; e.op = op; e.r1 = r1; e.r2 = r2; e.imm = imm; e.rd = rd; e.we = we; e.ill = ill;
    if (push) sb.push_back(e);
    bus.if_valid = 1'b1;
    bus.if_inst  = inst;
    bus.if_pc    = pc;
    tick();
    bus.if_valid = 1'b0;
  endtask

  task automatic fins(input logic f1, input logic [31:0] v1, input logic f2, input logic [31:0] v2);
    bus.rs1_read_fin = f1; bus.rs1_val = v1;
    bus.rs2_read_fin = f2; bus.rs2_val = v2;
    tick();
    bus.rs1_read_fin = 1'b0;
    bus.rs2_read_fin = 1'b0;
  endtask

  // monitor: compare on every execute-side handshake
  always @(negedge clk_in) begin
    if (!rst_in && bus.ex_valid && bus.ex_ready && rdy_in && !stall) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got output pc 0x%08h, required none", bus.ex_pc);
      end else begin
        mon_e = sb.pop_front();
        check("ex_pc",      bus.ex_pc,      mon_e.pc);
        check("ex_op",      32'(bus.ex_op), 32'(mon_e.op));
        check("ex_rs1_val", bus.ex_rs1_val, mon_e.r1);
        check("ex_rs2_val", bus.ex_rs2_val, mon_e.r2);
        check("ex_imm",     bus.ex_imm,     mon_e.imm);
        check("ex_rd",      32'(bus.ex_rd), 32'(mon_e.rd));
        check("ex_rd_we",   32'(bus.ex_rd_we),   32'(mon_e.we));
        check("ex_illegal", 32'(bus.ex_illegal), 32'(mon_e.ill));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; stall = 1'b0;
    bus.if_valid = 1'b0; bus.if_inst = '0; bus.if_pc = '0;
    bus.rs1_val = '0; bus.rs1_read_fin = 1'b0;
    bus.rs2_val = '0; bus.rs2_read_fin = 1'b0;
    bus.ex_ready = 1'b1;
    repeat (3) tick();
    check("rst_id_ready", 32'(bus.id_ready), 32'd1);
    check("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
    check("rst_rdy1",     32'(bus.rs1_read_rdy), 32'd0);
    check("rst_rdy2",     32'(bus.rs2_read_rdy), 32'd0);
    check("rst_ex_op",    32'(bus.ex_op), 32'd0);
    check("rst_ex_imm",   bus.ex_imm, 32'd0);
    rst_in = 1'b0;

    // 1: addi x1,x2,5; stray rs2 fin must be ignored
    issue(32'h00510093, 32'h100, OP_ADDI, 32'd7, 32'd0, 32'd5, 5'd1, 1'b1, 1'b0, 1'b1);
    check("t1_rdy1", 32'(bus.rs1_read_rdy), 32'd1);
    check("t1_rdy2", 32'(bus.rs2_read_rdy), 32'd0);
    check("t1_rs1_idx", 32'(bus.rs1), 32'd2);
    check("t1_id_ready", 32'(bus.id_ready), 32'd0);
    fins(1'b1, 32'd7, 1'b1, 32'h55);
    check("t1_ex_valid", 32'(bus.ex_valid), 32'd1);
    check("t1_rdy1_drop", 32'(bus.rs1_read_rdy), 32'd0);
    tick();
    check("t1_consumed", 32'(bus.ex_valid), 32'd0);
    check("t1_id_ready_back", 32'(bus.id_ready), 32'd1);

    // 2: add x3,x1,x2; fin1 at +1, rdy_in low for one cycle, fin2 at +3
    issue(32'h002081B3, 32'h104, OP_ADD, 32'h10, 32'h20, 32'd0, 5'd3, 1'b1, 1'b0, 1'b1);
    check("t2_rdy1", 32'(bus.rs1_read_rdy), 32'd1);
    check("t2_rdy2", 32'(bus.rs2_read_rdy), 32'd1);
    fins(1'b1, 32'h10, 1'b0, 32'd0);
    check("t2_rdy1_drop", 32'(bus.rs1_read_rdy), 32'd0);
    check("t2_rdy2_held", 32'(bus.rs2_read_rdy), 32'd1);
    rdy_in = 1'b0;
    tick();
    rdy_in = 1'b1;
    check("t2_frozen_rdy2", 32'(bus.rs2_read_rdy), 32'd1);
    check("t2_frozen_valid", 32'(bus.ex_valid), 32'd0);
    fins(1'b0, 32'd0, 1'b1, 32'h20);
    check("t2_ex_valid", 32'(bus.ex_valid), 32'd1);
    tick();

    // 3: lui x5,0x12345 -> no reads, ex_valid one cycle after accept
    issue(32'h123452B7, 32'h108, OP_LUI, 32'd0, 32'd0, 32'h12345000, 5'd5, 1'b1, 1'b0, 1'b1);
    check("t3_ex_valid", 32'(bus.ex_valid), 32'd1);
    check("t3_rdy1", 32'(bus.rs1_read_rdy), 32'd0);
    check("t3_rdy2", 32'(bus.rs2_read_rdy), 32'd0);
    tick();

    // 4: sw x2,-4(x1), both fins in the same cycle
    issue(32'hFE20AE23, 32'h10C, OP_SW, 32'h1000, 32'hDEADBEEF, 32'hFFFFFFFC, 5'd0, 1'b0, 1'b0, 1'b1);
    fins(1'b1, 32'h1000, 1'b1, 32'hDEADBEEF);
    check("t4_ex_valid", 32'(bus.ex_valid), 32'd1);
    tick();

    // 5a: xori x4,x3,-1 held in HOLD by ex_ready=0 for 5 cycles
    bus.ex_ready = 1'b0;
    issue(32'hFFF1C213, 32'h110, OP_XORI, 32'hA5A5A5A5, 32'd0, 32'hFFFFFFFF, 5'd4, 1'b1, 1'b0, 1'b1);
    fins(1'b1, 32'hA5A5A5A5, 1'b0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      check("t5_hold_valid", 32'(bus.ex_valid), 32'd1);
      check("t5_hold_id_ready", 32'(bus.id_ready), 32'd0);
      check("t5_hold_rs1_val", bus.ex_rs1_val, 32'hA5A5A5A5);
      tick();
    end
    bus.ex_ready = 1'b1;
    tick();
    check("t5_released", 32'(bus.ex_valid), 32'd0);

    // 5b: beq x1,x2,+8 with stall=1 for 3 cycles mid-READ, then stall in HOLD
    issue(32'h00208463, 32'h114, OP_BEQ, 32'd3, 32'd3, 32'd8, 5'd0, 1'b0, 1'b0, 1'b1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_stall_rdy1", 32'(bus.rs1_read_rdy), 32'd1);
      check("t5_stall_rdy2", 32'(bus.rs2_read_rdy), 32'd1);
      check("t5_stall_id_ready", 32'(bus.id_ready), 32'd0);
      check("t5_stall_valid", 32'(bus.ex_valid), 32'd0);
    end
    stall = 1'b0;
    fins(1'b1, 32'd3, 1'b1, 32'd3);
    check("t5_after_stall_valid", 32'(bus.ex_valid), 32'd1);
    stall = 1'b1;
    tick();
    check("t5_stall_hold_valid", 32'(bus.ex_valid), 32'd1);
    stall = 1'b0;
    tick();
    check("t5_stall_consumed", 32'(bus.ex_valid), 32'd0);

    // 6: reset during READ discards the instruction
    issue(32'h002081B3, 32'h118, OP_ADD, 32'd0, 32'd0, 32'd0, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    check("t6_rdy1", 32'(bus.rs1_read_rdy), 32'd0);
    check("t6_rdy2", 32'(bus.rs2_read_rdy), 32'd0);
    check("t6_ex_valid", 32'(bus.ex_valid), 32'd0);
    check("t6_id_ready", 32'(bus.id_ready), 32'd1);

    // all-zero word is illegal and needs no reads
    issue(32'h00000000, 32'h11C, OP_NOP, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    check("t6_ill_valid", 32'(bus.ex_valid), 32'd1);
    check("t6_ill_rdy1", 32'(bus.rs1_read_rdy), 32'd0);
    check("t6_ill_rdy2", 32'(bus.rs2_read_rdy), 32'd0);
    tick();

    repeat (2) tick();
    check("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
